// File: rtl/prbs_lfsr_pkg.sv
// Shared types, tap constants and feedback helper for the parametrised PRBS LFSR.
package prbs_lfsr_pkg;

  typedef enum logic {HUNT, LOCKED} chk_state_t;

  localparam int MAX_WIDTH = 64;

  localparam logic [6:0]  TAPS_PRBS7  = 7'h60;
  localparam logic [14:0] TAPS_PRBS15 = 15'h6000;
  localparam logic [22:0] TAPS_PRBS23 = 23'h420000;
  localparam logic [30:0] TAPS_PRBS31 = 31'h48000000;
  localparam logic [25:0] TAPS_26     = 26'h2000023;

  function automatic logic lfsr_fb(input logic [MAX_WIDTH-1:0] state,
                                   input logic [MAX_WIDTH-1:0] taps);
    return ^(state & taps);
  endfunction

  // Widths without a known polynomial fall back to x^W+x+1, which is not always maximal-length.
  function automatic logic [MAX_WIDTH-1:0] default_taps(input int width);
    logic [MAX_WIDTH-1:0] t;
    case (width)
      7:       t = MAX_WIDTH'(TAPS_PRBS7);
      15:      t = MAX_WIDTH'(TAPS_PRBS15);
      23:      t = MAX_WIDTH'(TAPS_PRBS23);
      26:      t = MAX_WIDTH'(TAPS_26);
      31:      t = MAX_WIDTH'(TAPS_PRBS31);
      default: t = (MAX_WIDTH'(1) << (width - 1)) | MAX_WIDTH'(1);
    endcase
    return t;
  endfunction

endpackage

// File: rtl/prbs_lfsr_if.sv
// Control and status bundle of one prbs_lfsr instance; the slave side is the LFSR itself.
interface prbs_lfsr_if #(
  parameter int WIDTH = 26,
  parameter int CNT_W = 16
);
  logic             load;
  logic [WIDTH-1:0] din;
  logic             en;
  logic             mode;
  logic             rx_bit;
  logic [WIDTH-1:0] q;
  logic             out_bit;
  logic             locked;
  logic [CNT_W-1:0] err_cnt;
  logic             lockup;

  modport master (
    output load, din, en, mode, rx_bit,
    input  q, out_bit, locked, err_cnt, lockup
  );

  modport slave (
    input  load, din, en, mode, rx_bit,
    output q, out_bit, locked, err_cnt, lockup
  );
endinterface

// File: rtl/prbs_lfsr_core.sv
// Fibonacci shift register: load/recover/shift/hold muxing plus feedback generation.
module lfsr_core
  import prbs_lfsr_pkg::*;
#(
  parameter int               WIDTH = 26,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             shift_in,
  input  logic             recover,
  output logic [WIDTH-1:0] q,
  output logic             fb
);

  assign fb = lfsr_fb(MAX_WIDTH'(q), MAX_WIDTH'(TAPS));

  // The new bit enters at bit 0, so the oldest bit leaves at the top as the serial output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= SEED;
    else if (load)
      q <= din;
    else if (en) begin
      if (recover)
        q <= SEED;
      else
        q <= {q[WIDTH-2:0], shift_in};
    end
  end

endmodule

// File: rtl/prbs_lfsr.sv
// PRBS generator/self-synchronising checker with lock detection and error counting.
// Optional all-zero recovery is enabled by defining LFSR_LOCKUP_RECOVER_EN.
module prbs_lfsr
  import prbs_lfsr_pkg::*;
#(
  parameter int               WIDTH       = 26,
  parameter logic [WIDTH-1:0] TAPS        = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED        = WIDTH'(1),
  parameter int               LOSS_THRESH = 4,
  parameter int               CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  prbs_lfsr_if.slave bus
);

  localparam int MATCH_W = $clog2(WIDTH + 1);
  localparam int BAD_W   = $clog2(LOSS_THRESH + 1);

  chk_state_t         state;
  logic [MATCH_W-1:0] match_cnt;
  logic [BAD_W-1:0]   bad_cnt;
  logic [CNT_W-1:0]   err_cnt;
  logic               locked;
  logic [WIDTH-1:0]   q;
  logic               fb;
  logic               shift_in;
  logic               recover;
  logic               lockup;
  logic               match;

  assign match    = (bus.rx_bit == fb);
  assign lockup   = (q == '0);
  // While hunting, the register self-loads from the received stream.
  assign shift_in = (bus.mode && state == HUNT) ? bus.rx_bit : fb;

`ifdef LFSR_LOCKUP_RECOVER_EN
  assign recover = lockup && (!bus.mode || state == LOCKED);
`else
  assign recover = 1'b0;
`endif

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (bus.load),
    .din      (bus.din),
    .en       (bus.en),
    .shift_in (shift_in),
    .recover  (recover),
    .q        (q),
    .fb       (fb)
  );

  // Lock needs WIDTH+1 consecutive matches; loss needs LOSS_THRESH consecutive mismatches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      match_cnt <= '0;
      bad_cnt   <= '0;
      err_cnt   <= '0;
      locked    <= 1'b0;
    end else if (bus.load) begin
      state     <= HUNT;
      match_cnt <= '0;
      bad_cnt   <= '0;
      err_cnt   <= '0;
      locked    <= 1'b0;
    end else if (bus.en && bus.mode) begin
      case (state)
        HUNT: begin
          if (!match)
            match_cnt <= '0;
          else if (match_cnt == MATCH_W'(WIDTH)) begin
            state     <= LOCKED;
            locked    <= 1'b1;
            match_cnt <= '0;
          end else
            match_cnt <= match_cnt + MATCH_W'(1);
        end
        LOCKED: begin
          if (match)
            bad_cnt <= '0;
          else begin
            if (err_cnt != '1)
              err_cnt <= err_cnt + CNT_W'(1);
            if (bad_cnt == BAD_W'(LOSS_THRESH - 1)) begin
              state   <= HUNT;
              locked  <= 1'b0;
              bad_cnt <= '0;
            end else
              bad_cnt <= bad_cnt + BAD_W'(1);
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  assign bus.q       = q;
  assign bus.out_bit = q[WIDTH-1];
  assign bus.locked  = locked;
  assign bus.err_cnt = err_cnt;
  assign bus.lockup  = lockup;

endmodule

// File: tb/tb_prbs_lfsr.sv
// Directed bench: a generator instance feeds a checker instance; expected values go through a scoreboard queue.
module tb_prbs_lfsr;

  localparam int W  = 26;
  localparam int CW = 16;
  localparam logic [W-1:0] TAPS_REF = 26'h2000023;
  localparam logic [W-1:0] LOAD_PAT = 26'b11011001010110101101011001;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       flip  = 1'b0;
  logic [W-1:0] mq;
  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  prbs_lfsr_if #(.WIDTH(W), .CNT_W(CW)) gen_if ();
  prbs_lfsr_if #(.WIDTH(W), .CNT_W(CW)) chk_if ();

  assign chk_if.rx_bit = gen_if.out_bit ^ flip;

  prbs_lfsr #(.WIDTH(W), .TAPS(26'h2000023), .SEED(26'd1), .LOSS_THRESH(4), .CNT_W(CW)) u_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (gen_if)
  );

  prbs_lfsr #(.WIDTH(W), .TAPS(26'h2000023), .SEED(26'd1), .LOSS_THRESH(4), .CNT_W(CW)) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (chk_if)
  );

  function automatic logic [W-1:0] refNext(input logic [W-1:0] v);
    logic f;
    f = 1'b0;
    for (int i = 0; i < W; i++)
      if (TAPS_REF[i]) f = f ^ v[i];
    return {v[W-2:0], f};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic g_load, input logic [W-1:0] g_din, input logic g_en,
                               input logic g_mode, input logic c_load, input logic [W-1:0] c_din,
                               input logic c_en, input logic c_mode);
    gen_if.load = g_load;
    gen_if.din  = g_din;
    gen_if.en   = g_en;
    gen_if.mode = g_mode;
    chk_if.load = c_load;
    chk_if.din  = c_din;
    chk_if.en   = c_en;
    chk_if.mode = c_mode;
  endtask

  task automatic pushExpect(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input logic [63:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  // Generator and checker both advance; the model tracks the generator only.
  task automatic runBoth(input int n);
    for (int i = 0; i < n; i++) begin
      mq = refNext(mq);
      step();
    end
  endtask

  initial begin
    gen_if.rx_bit = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    repeat (2) step();

    pushExpect("rst_gen_q", 64'd1);
    pushExpect("rst_out_bit", 64'd0);
    pushExpect("rst_locked", 64'd0);
    pushExpect("rst_err_cnt", 64'd0);
    pushExpect("rst_lockup", 64'd0);
    pushExpect("rst_chk_q", 64'd1);
    checkOutput(64'(gen_if.q));
    checkOutput(64'(gen_if.out_bit));
    checkOutput(64'(chk_if.locked));
    checkOutput(64'(chk_if.err_cnt));
    checkOutput(64'(gen_if.lockup));
    checkOutput(64'(chk_if.q));

    rst_n = 1'b1;
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    mq = 26'd1;
    for (int i = 0; i < 64; i++) begin
      mq = refNext(mq);
      pushExpect("gen_q", 64'(mq));
      pushExpect("gen_out_bit", 64'(mq[W-1]));
      step();
      checkOutput(64'(gen_if.q));
      checkOutput(64'(gen_if.out_bit));
    end

    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    pushExpect("hold_q", 64'(mq));
    step();
    checkOutput(64'(gen_if.q));

    applyStimulus(1'b1, LOAD_PAT, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      pushExpect("load_q", 64'(LOAD_PAT));
      step();
      checkOutput(64'(gen_if.q));
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    mq = refNext(LOAD_PAT);
    pushExpect("post_load_q", 64'(mq));
    step();
    checkOutput(64'(gen_if.q));

    // Generator starts 26 steps ahead so the checker's seed state predicts the first received bit.
    applyStimulus(1'b1, 26'd1, 1'b0, 1'b0, 1'b1, 26'd1, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    mq = 26'd1;
    runBoth(W);
    pushExpect("ahead_gen_q", 64'(mq));
    checkOutput(64'(gen_if.q));

    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    runBoth(W);
    pushExpect("lock_26_locked", 64'd0);
    checkOutput(64'(chk_if.locked));
    runBoth(1);
    pushExpect("lock_27_locked", 64'd1);
    pushExpect("lock_err_cnt", 64'd0);
    checkOutput(64'(chk_if.locked));
    checkOutput(64'(chk_if.err_cnt));

    flip = 1'b1;
    runBoth(1);
    flip = 1'b0;
    pushExpect("single_err_cnt", 64'd1);
    pushExpect("single_locked", 64'd1);
    checkOutput(64'(chk_if.err_cnt));
    checkOutput(64'(chk_if.locked));
    runBoth(1);
    pushExpect("clean_locked", 64'd1);
    checkOutput(64'(chk_if.locked));

    flip = 1'b1;
    runBoth(3);
    pushExpect("burst3_locked", 64'd1);
    pushExpect("burst3_err_cnt", 64'd4);
    checkOutput(64'(chk_if.locked));
    checkOutput(64'(chk_if.err_cnt));
    runBoth(1);
    flip = 1'b0;
    pushExpect("burst4_locked", 64'd0);
    pushExpect("burst4_err_cnt", 64'd5);
    checkOutput(64'(chk_if.locked));
    checkOutput(64'(chk_if.err_cnt));

    runBoth(W);
    pushExpect("relock_26_locked", 64'd0);
    checkOutput(64'(chk_if.locked));
    runBoth(1);
    pushExpect("relock_27_locked", 64'd1);
    pushExpect("relock_err_cnt", 64'd5);
    checkOutput(64'(chk_if.locked));
    checkOutput(64'(chk_if.err_cnt));

    #2;
    rst_n = 1'b0;
    #1;
    pushExpect("async_rst_chk_q", 64'd1);
    pushExpect("async_rst_gen_q", 64'd1);
    pushExpect("async_rst_locked", 64'd0);
    pushExpect("async_rst_err_cnt", 64'd0);
    checkOutput(64'(chk_if.q));
    checkOutput(64'(gen_if.q));
    checkOutput(64'(chk_if.locked));
    checkOutput(64'(chk_if.err_cnt));
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;

    applyStimulus(1'b1, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    pushExpect("zero_load_q", 64'd0);
    pushExpect("zero_load_lockup", 64'd1);
    step();
    checkOutput(64'(gen_if.q));
    checkOutput(64'(gen_if.lockup));
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
`ifdef LFSR_LOCKUP_RECOVER_EN
    pushExpect("recover_q", 64'd1);
    pushExpect("recover_lockup", 64'd0);
    step();
    checkOutput(64'(gen_if.q));
    checkOutput(64'(gen_if.lockup));
    mq = refNext(26'd1);
    pushExpect("recover_next_q", 64'(mq));
    step();
    checkOutput(64'(gen_if.q));
`else
    for (int i = 0; i < 10; i++) begin
      pushExpect("stuck_q", 64'd0);
      pushExpect("stuck_lockup", 64'd1);
      step();
      checkOutput(64'(gen_if.q));
      checkOutput(64'(gen_if.lockup));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prbs_lfsr.md
# prbs_lfsr

Parametrised Fibonacci LFSR supporting both PRBS generation and PRBS checking, the next generation of the team's fixed 26-bit LFSR. It is generalised in width, tap polynomial and seed, and adds a step enable and a self-synchronising checker with lock detection and error counting. It also detects the all-zero lock-up state. It sits at the test/BIST edge of datapaths: one instance drives a pattern, another instance checks the returned stream.

## Interface
- WIDTH, 26: register length, 3..64.
- TAPS, 26'h2000023: feedback mask, bit i set means q[i] is XORed into feedback. The default is x^26+x^6+x^2+x+1.
- SEED, 1: reset and auto-recovery value; must be non-zero.
- LOSS_THRESH, 4: consecutive mismatches in LOCKED that cause a return to HUNT.
- CNT_W, 16: error counter width.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- load  in  1  synchronous parallel load.
- din  in  WIDTH  parallel load data.
- en  in  1  step enable: one shift per cycle when high.
- mode  in  1  0 = generate, 1 = check.
- rx_bit  in  1  serial input under check; sampled only when en=1 and mode=1.
- q  out  WIDTH  register state.
- out_bit  out  1  serial output, equal to q[WIDTH-1].
- locked  out  1  checker is in the LOCKED state.
- err_cnt  out  CNT_W  mismatches counted in LOCKED; saturates.
- lockup  out  1  q == 0, combinational from q.

## Operation
- Feedback: fb = XOR over i of (q[i] & TAPS[i]).
- Generate step: q <= {q[WIDTH-2:0], fb}.
- Priority per cycle is rst_n, then load, then en.
  - load: q <= din, state <= HUNT, match_cnt, bad_cnt and err_cnt cleared. This applies in either mode.
  - en=0 and load=0: all state holds.
- Checker FSM, active only when mode=1 and en=1:
  - HUNT: q <= {q[WIDTH-2:0], rx_bit}, so the register self-loads from the stream. If rx_bit == fb, match_cnt increments; otherwise match_cnt <= 0. When match_cnt reaches WIDTH on a matching bit, go to LOCKED, clear match_cnt, and assert locked from the next cycle.
  - LOCKED: q <= {q[WIDTH-2:0], fb}; the register free-runs and ignores rx_bit for the shift. On a mismatch, err_cnt increments (saturating at all-ones) and bad_cnt increments. On a match, bad_cnt <= 0. When bad_cnt reaches LOSS_THRESH, go to HUNT, clear bad_cnt and deassert locked. err_cnt is retained.
- Mode change while running: the FSM state is frozen while mode=0, and q follows the generate rule.
- Lock-up: with q == 0 and no recovery, the register stays at zero and lockup stays high.

## Timing
- Reset values: q = SEED, out_bit = SEED[WIDTH-1], locked = 0, err_cnt = 0, lockup = 0, FSM = HUNT, internal counters 0.
- Reset is asynchronous assert and synchronous-safe deassert. Reset mid-run discards all state immediately.
- out_bit, q, locked and err_cnt are registered and update on the edge following the enabled cycle. lockup is combinational from q, so it has zero latency relative to q.
- Lock time with a clean stream from HUNT: WIDTH+1 enabled cycles minimum (fill plus WIDTH matches overlapping). locked rises 1 cycle after the final match.
- Loss time: LOSS_THRESH consecutive enabled mismatches. locked falls 1 cycle after the last of them.
- load with en=1 in the same cycle: load wins and no shift occurs.

## Configuration
- LFSR_LOCKUP_RECOVER_EN defined: on an enabled cycle with q == 0 in generate mode or in LOCKED, q <= SEED instead of shifting. lockup still pulses for the cycle in which q == 0.
- Macro undefined: no recovery. An all-zero state persists until load or reset, and lockup stays high.

## Structure
- Package prbs_lfsr_pkg holds:
  - the state enum {HUNT, LOCKED};
  - default tap constants for common polynomials (PRBS7, PRBS15, PRBS23, PRBS31, 26-bit);
  - a function that computes fb from q and TAPS.
- Sub-module lfsr_core holds the WIDTH-bit register, load/shift/hold muxing and fb generation. The top level adds the checker FSM, the counters and the recovery logic.

## Test plan
- Reset then generate: release rst_n with mode=0, en=1 and defaults. Required: q = 1 after reset. The sequence repeats with period 2^26-1, so check the first 64 outputs against a reference model.
- Load override: assert load with din=26'b11011001010110101101011001 and en=1 for 2 cycles, then release. Required: q holds the din value during load, and the next step produces {din[24:0], fb}.
- Checker lock: loop a generator output into rx_bit of a second instance with mode=1. Required: locked rises 27 cycles after the first enabled cycle and err_cnt stays at 0.
- Error injection: once locked, flip 1 isolated bit, then flip 4 consecutive bits. Required: err_cnt goes to 1 and locked stays high after the single flip. After the burst, err_cnt = 5 and locked falls, then it re-locks after WIDTH+1 clean bits.
- Lock-up, macro undefined: load 0. Required: lockup=1 and q=0 for 10 enabled cycles.
- Lock-up, with LFSR_LOCKUP_RECOVER_EN: load 0. Required: q = SEED after 1 enabled cycle and lockup falls.
